sram_blk_writer: RTL
====================

// Module: sram_blk_writer
// PURPOSE
//   Multi-beat block write engine between the per-port data FIFO and one SRAM bank.
//   Accepts a block address via valid/ready, then drains BEATS words from a FWFT FIFO into
//   consecutive SRAM word addresses {blk_addr, beat}, honouring FIFO-empty and SRAM stall.
//   Generalises the single-beat write stage: parametrised width/depth, burst counter,
//   back-pressure, completion pulse.
// PARAMETERS
//   ADDR_W   10   block address width (number of blocks = 2**ADDR_W)
//   DATA_W   64   SRAM/FIFO word width
//   BEATS    8    words per block; power of 2, >= 2; BEAT_W = $clog2(BEATS)
// PORTS
//   i_clk          in   1               clock
//   i_rst_n        in   1               asynchronous, active-low reset
//   i_blk_addr     in   ADDR_W          block address to write
//   i_blk_vld      in   1               block request valid
//   o_blk_rdy      out  1               engine can accept a request (IDLE)
//   i_fifo_data    in   DATA_W          FWFT FIFO head word, valid whenever !i_fifo_empty
//   i_fifo_empty   in   1               FIFO empty
//   o_fifo_ren     out  1               pop FIFO head this cycle
//   i_sram_stall   in   1               SRAM port busy; current write must be held
//   o_sram_addr    out  ADDR_W+BEAT_W   SRAM word address {blk_addr, beat}
//   o_sram_wen     out  1               SRAM write enable
//   o_sram_data    out  DATA_W          SRAM write data
//   o_blk_done     out  1               1-cycle pulse: last beat of block written
//   o_busy         out  1               state != IDLE or write pending in output stage
// BEHAVIOUR
//   Reset: state=IDLE, beat_cnt=0; o_sram_addr/o_sram_wen/o_sram_data/o_blk_done=0;
//     o_blk_rdy=1, o_fifo_ren=0, o_busy=0. Mid-block reset aborts the block; remaining
//     FIFO words are left unconsumed; no done pulse.
//   FSM: IDLE -> WRITE on i_blk_vld && o_blk_rdy (latch blk_addr, beat_cnt=0).
//        WRITE -> IDLE in the cycle the ren for beat BEATS-1 is issued.
//   o_blk_rdy = (state==IDLE), combinational; i_blk_vld while busy is not accepted.
//   hold = o_sram_wen && i_sram_stall.
//   o_fifo_ren = (state==WRITE) && !i_fifo_empty && !hold  (combinational).
//   Output stage (registered, 1-cycle latency from ren):
//     ren=1:            o_sram_wen<=1, o_sram_data<=i_fifo_data,
//                       o_sram_addr<={blk_addr,beat_cnt}, beat_cnt<=beat_cnt+1 (wraps to 0).
//     ren=0 && hold:    all three outputs hold their values (write replayed).
//     ren=0 && !hold:   o_sram_wen<=0; addr/data hold last value.
//   A write completes in any cycle with o_sram_wen && !i_sram_stall.
//   o_blk_done<=1 the cycle after completion of the beat with beat field == BEATS-1, else 0.
//   FIFO empty mid-block: no ren, o_sram_wen drops; resumes on next non-empty cycle;
//     address continuity preserved.
//   New block accepted in IDLE while last beat is still in output stage (stalled or not);
//     next block's first ren only issues when !hold, so order is preserved.
//   Min block time: BEATS cycles of ren + 1 IDLE cycle; throughput BEATS/(BEATS+1).
//   o_busy = (state!=IDLE) || o_sram_wen.
// TESTING
//   1 reset then blk_addr=0x005, FIFO holds 8 words D0..D7, no stall -> ren 8 consecutive
//     cycles; wen addrs 0x028..0x02F with D0..D7 one cycle later; done 1 cycle after 0x02F.
//   2 i_fifo_empty=1 after 3 words, refilled 4 cycles later -> addrs +0..+2, wen gap of 4
//     cycles, resume at +3; total 8 writes, single done pulse.
//   3 i_sram_stall=1 for 3 cycles while beat 4 on port -> ren=0, addr/data/wen frozen
//     3 cycles, beat 4 written once stall drops, no lost or duplicated beat.
//   4 back-to-back requests blk 0x3FF then 0x000 with i_blk_vld held -> second accepted
//     cycle after first's last ren; addr 0x1FFF then 0x0000 (no overflow into upper bits).
//   5 i_rst_n low after beat 2 of a block -> outputs 0 asynchronously, rdy=1,
//     no done; new request after reset starts at beat 0.
//   6 i_blk_vld pulsed while WRITE -> ignored, blk_addr unchanged, o_blk_rdy stays 0.

Source files
------------

// File: rtl/sram_blk_writer_if.sv
// Bundle of request, FIFO-side and SRAM-side signals for the block write engine.
// Block request: a request transfers on a rising clock edge where i_blk_vld && o_blk_rdy.
// The producer holds i_blk_addr steady while i_blk_vld is high and the engine is not ready.
interface sram_blk_writer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8
);
  localparam int BEAT_W = $clog2(BEATS);

  logic [ADDR_W-1:0]        i_blk_addr;
  logic                     i_blk_vld;
  logic                     o_blk_rdy;
  logic [DATA_W-1:0]        i_fifo_data;
  logic                     i_fifo_empty;
  logic                     o_fifo_ren;
  logic                     i_sram_stall;
  logic [ADDR_W+BEAT_W-1:0] o_sram_addr;
  logic                     o_sram_wen;
  logic [DATA_W-1:0]        o_sram_data;
  logic                     o_blk_done;
  logic                     o_busy;
  logic                     o_dbg_state;

  modport slave (
    input  i_blk_addr, i_blk_vld, i_fifo_data, i_fifo_empty, i_sram_stall,
    output o_blk_rdy, o_fifo_ren, o_sram_addr, o_sram_wen, o_sram_data,
           o_blk_done, o_busy, o_dbg_state
  );

  modport master (
    output i_blk_addr, i_blk_vld, i_fifo_data, i_fifo_empty, i_sram_stall,
    input  o_blk_rdy, o_fifo_ren, o_sram_addr, o_sram_wen, o_sram_data,
           o_blk_done, o_busy, o_dbg_state
  );
endinterface

// File: rtl/sram_blk_writer.sv
// Block write engine: accepts a block address, then drains BEATS words from a FWFT FIFO
// into consecutive SRAM word addresses {blk_addr, beat}, honouring FIFO-empty and SRAM stall.
module sram_blk_writer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  sram_blk_writer_if.slave   bus
);
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDR_W-1:0]        r_blk_addr;
  logic [BEAT_W-1:0]        r_beat_cnt;
  logic [ADDR_W+BEAT_W-1:0] r_sram_addr;
  logic                     r_sram_wen;
  logic [DATA_W-1:0]        r_sram_data;
  logic                     r_blk_done;

  logic w_hold;
  logic w_ren;
  logic w_accept;
  logic w_last_ren;
  logic w_last_compl;

  // A stalled write sits in the output stage; no new pop until it drains, which also
  // keeps a freshly accepted block behind the previous block's last beat.
  always_comb begin
    w_hold       = r_sram_wen && bus.i_sram_stall;
    w_ren        = (r_state == S_WRITE) && !bus.i_fifo_empty && !w_hold;
    w_accept     = (r_state == S_IDLE) && bus.i_blk_vld;
    w_last_ren   = w_ren && (r_beat_cnt == LAST_BEAT);
    w_last_compl = r_sram_wen && !bus.i_sram_stall &&
                   (r_sram_addr[BEAT_W-1:0] == LAST_BEAT);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_nxt = S_WRITE;
      S_WRITE: if (w_last_ren) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blk_addr <= '0;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_blk_addr <= bus.i_blk_addr;
      r_beat_cnt <= '0;
    end else if (w_ren) begin
      r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
    end
  end

  // Output stage: a popped word lands here one cycle after its ren; replayed while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sram_wen  <= 1'b0;
      r_sram_addr <= '0;
      r_sram_data <= '0;
      r_blk_done  <= 1'b0;
    end else begin
      r_blk_done <= w_last_compl;
      if (w_ren) begin
        r_sram_wen  <= 1'b1;
        r_sram_addr <= {r_blk_addr, r_beat_cnt};
        r_sram_data <= bus.i_fifo_data;
      end else if (!w_hold) begin
        r_sram_wen  <= 1'b0;
      end
    end
  end

  assign bus.o_blk_rdy   = (r_state == S_IDLE);
  assign bus.o_fifo_ren  = w_ren;
  assign bus.o_sram_addr = r_sram_addr;
  assign bus.o_sram_wen  = r_sram_wen;
  assign bus.o_sram_data = r_sram_data;
  assign bus.o_blk_done  = r_blk_done;
  assign bus.o_busy      = (r_state != S_IDLE) || r_sram_wen;
  assign bus.o_dbg_state = r_state;
endmodule
